// File: rtl/freq_table_builder.sv
// -----------------------------------------------------------------------------
// freq_table_builder
//
// Builds a histogram of symbol occurrences for one block of symbols. A start
// pulse clears the table. Each accepted symbol then increments its bin and the
// running total. A symbol flagged as last closes the block, and the table
// holds stable until the next start.
//
// Ports
//   clk_in          : clock, rising edge
//   rst_n_in        : asynchronous active-low reset
//   start_in        : one-cycle request to clear the table and begin counting
//   sym_in          : symbol value (bin index)
//   sym_valid_in    : sym_in valid this cycle
//   sym_last_in     : final symbol of the block (qualified by sym_valid_in)
//   sym_ready_out   : symbol accepted this cycle when valid (COUNT only)
//   freq_table_out  : per-symbol counts, index = symbol
//   total_out       : saturating count of accepted symbols
//   busy_out        : high while clearing or counting
//   done_out        : level, table complete and stable
//   sat_out         : sticky, a bin or the total saturated in this block
// -----------------------------------------------------------------------------
module freq_table_builder #(
    parameter int TABLE_SIZE = 256,
    parameter int DATA_WIDTH = 16,
    parameter int SYM_WIDTH  = 8
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            start_in,
    input  logic [SYM_WIDTH-1:0]            sym_in,
    input  logic                            sym_valid_in,
    input  logic                            sym_last_in,
    output logic                            sym_ready_out,
    output logic [DATA_WIDTH-1:0]           freq_table_out [TABLE_SIZE],
    output logic [DATA_WIDTH+SYM_WIDTH-1:0] total_out,
    output logic                            busy_out,
    output logic                            done_out,
    output logic                            sat_out
);

    localparam int TOT_W = DATA_WIDTH + SYM_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   table_q [TABLE_SIZE];
    logic [TOT_W-1:0]        total_q;
    logic                    ready_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    sat_q;

    logic                    accept;
    logic [DATA_WIDTH-1:0]   bin_cur;
    logic                    bin_full;
    logic                    total_full;
    logic [DATA_WIDTH-1:0]   bin_d;
    logic [TOT_W-1:0]        total_d;

    // The ready flag is a register, so accept has no combinational path back
    // to sym_ready_out. The bin read-modify-write happens in one edge, which
    // lets back-to-back hits on the same symbol each count.
    assign accept     = sym_valid_in & ready_q;
    assign bin_cur    = table_q[sym_in];
    assign bin_full   = &bin_cur;
    assign total_full = &total_q;
    assign bin_d      = bin_full   ? bin_cur : bin_cur + 1'b1;
    assign total_d    = total_full ? total_q : total_q + 1'b1;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            total_q <= '0;
            for (int i = 0; i < TABLE_SIZE; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            case (state_q)
                // IDLE and DONE both clear on the edge that enters CLEAR, so
                // the table already reads zero during the CLEAR cycle.
                IDLE, DONE: begin
                    if (start_in) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        sat_q   <= 1'b0;
                        total_q <= '0;
                        for (int i = 0; i < TABLE_SIZE; i++) begin
                            table_q[i] <= '0;
                        end
                    end
                end
                CLEAR: begin
                    state_q <= COUNT;
                    ready_q <= 1'b1;
                end
                COUNT: begin
                    if (accept) begin
                        table_q[sym_in] <= bin_d;
                        total_q         <= total_d;
                        if (bin_full || total_full) begin
                            sat_q <= 1'b1;
                        end
                        if (sym_last_in) begin
                            state_q <= DONE;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sym_ready_out  = ready_q;
    assign freq_table_out = table_q;
    assign total_out      = total_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;
    assign sat_out        = sat_q;

endmodule
